mux_n_pipe: RTL
===============

// Module: mux_n_pipe
// PURPOSE
//  Parametrised N:1 multiplexer, successor to the 2:1 gate-level mux.
//  Adds configurable data width and channel count, a registered output stage and a
//  valid/ready handshake on every input and on the output.
//  Sits between multiple producer channels and a single consumer.
//  Optional round-robin mode lets the block pick the source without an external select.
// PARAMETERS
//  WIDTH  8  data bits per channel
//  N      4  number of input channels (>=2; need not be a power of 2)
//  SW     $clog2(N)  derived select width; never overridden
// PORTS
//  clk      in   1        single clock; all state updates on rising edge
//  rst      in   1        asynchronous, active-high reset
//  d        in   N*WIDTH  channel data; channel i = d[i*WIDTH +: WIDTH]
//  d_valid  in   N        per-channel valid
//  d_ready  out  N        per-channel ready (combinational)
//  sel      in   SW       channel select in fixed mode
//  mode     in   1        0 = fixed select, 1 = round-robin (ignored without macro)
//  y        out  WIDTH    registered output data
//  y_ch     out  SW       source channel of the data in y
//  y_valid  out  1        output valid
//  y_ready  in   1        consumer ready
// BEHAVIOUR
//  - Reset (async, rst=1): y=0, y_ch=0, y_valid=0, rr_ptr=0. d_ready=0 while rst is high.
//  - load = (!y_valid || y_ready). grant = selected channel g.
//  - d_ready[i] = load && (i==g); all other bits 0. Transfer on channel g when d_valid[g] && d_ready[g].
//  - On a transfer, the next edge sets y=d[g], y_ch=g and y_valid=1. Latency is 1 cycle.
//  - If load and there is no transfer: y_valid goes to 0 and y/y_ch hold their old values.
//  - If y_valid && !y_ready: y, y_ch and y_valid hold (stall). No d_ready bit is asserted.
//  - Full throughput: one word per cycle while y_ready stays 1.
//  - Fixed mode: g=sel.
//  - sel>=N (possible when N is not a power of 2): no grant, all d_ready=0, y_valid drops after a consumed word.
//  - sel or mode changing during a stall affects only the next load. It never affects held data.
//  - No combinational path from d to y; the only one is d_valid/y_ready/sel -> d_ready.
//  - Reset mid-transfer: the pending word is discarded and the block returns to reset state immediately.
// CONFIGURATION
//  Macro MUX_N_PIPE_RR_EN:
//  - Defined: mode=1 enables round-robin. g = first channel with d_valid set, searching from rr_ptr
//    upward and wrapping N-1 -> 0. No valid channel means no grant.
//    On each transfer rr_ptr <= (g+1) mod N; otherwise rr_ptr holds. Fixed mode leaves rr_ptr unchanged.
//  - Undefined: mode is ignored, no arbiter and no rr_ptr are built, behaviour is always fixed select.
// STRUCTURE
//  - Package mux_pkg holds:
//    - typedef enum logic {MUX_MODE_SEL=1'b0, MUX_MODE_RR=1'b1} mux_mode_e;
//    - localparam defaults MUX_WIDTH_DEF=8 and MUX_N_DEF=4.
//  - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs gnt_idx and gnt_vld.
//    Purely combinational; instantiated only under MUX_N_PIPE_RR_EN.
//  - Top level holds the output register, the rr_ptr register and the ready logic.
// TESTING
//  1. Reset: assert rst mid-stream with y_valid=1 -> y=0, y_ch=0, y_valid=0, d_ready=0 in the same cycle, without waiting for a clock edge.
//  2. Fixed, N=4, W=8: sel=2, d2=8'hA5 valid, y_ready=1
//     -> d_ready=4'b0100; next cycle y=A5, y_ch=2, y_valid=1.
//  3. Stall: y_valid=1 with y_ready=0 for 3 cycles while sel and d change -> y, y_ch held and d_ready=0.
//     On release the new word lands the next cycle.
//  4. Back-to-back: y_ready=1 with 16 words on ch1 -> 16 consecutive y_valid cycles, data in order, no bubbles.
//  5. N=3 with sel=3 -> d_ready=0; y_valid falls after the held word is consumed.
//  6. RR (macro on, mode=1): all 4 channels valid for 8 transfers
//     -> y_ch sequence 0,1,2,3,0,1,2,3.
//     With only ch3 and ch0 valid and rr_ptr=3 -> 3 then 0 (wrap).
//     Macro off with mode=1 -> behaves exactly as test 2.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and parameter defaults for the N:1 pipelined multiplexer.
package mux_pkg;

  typedef enum logic {
    MUX_MODE_SEL = 1'b0,
    MUX_MODE_RR  = 1'b1
  } mux_mode_e;

  localparam int MUX_WIDTH_DEF = 8;
  localparam int MUX_N_DEF     = 4;

endpackage

// File: rtl/mux_n_pipe_if.sv
// Producer/consumer bundle for mux_n_pipe: N input channels, one output channel.
interface mux_n_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) ();

  logic [N*WIDTH-1:0] d;
  logic [N-1:0]       d_valid;
  logic [N-1:0]       d_ready;
  logic [SW-1:0]      sel;
  logic               mode;
  logic [WIDTH-1:0]   y;
  logic [SW-1:0]      y_ch;
  logic               y_valid;
  logic               y_ready;

  modport master (
    output d, d_valid, sel, mode, y_ready,
    input  d_ready, y, y_ch, y_valid
  );

  modport slave (
    input  d, d_valid, sel, mode, y_ready,
    output d_ready, y, y_ch, y_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [SW-1:0] idx;

  // Scan from farthest to nearest so the channel closest to ptr wins last.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = SW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 mux with per-channel valid/ready and a registered output stage.
// Define MUX_N_PIPE_RR_EN to build the round-robin source picker (mode=1).
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF,
  parameter int N     = MUX_N_DEF,
  parameter int SW    = $clog2(N)
) (
  input logic         clk,
  input logic         rst,
  mux_n_pipe_if.slave bus
);

  logic [SW-1:0]    g;
  logic             g_vld;
  logic             load;
  logic             xfer;
  logic [N-1:0]     ready;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] y_q;
  logic [SW-1:0]    y_ch_q;
  logic             y_valid_q;

  assign load = !y_valid_q || bus.y_ready;

`ifdef MUX_N_PIPE_RR_EN
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] arb_idx;
  logic          arb_vld;
  logic          rr_on;

  assign rr_on = (mux_mode_e'(bus.mode) == MUX_MODE_RR);

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req     (bus.d_valid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign g     = rr_on ? arb_idx : bus.sel;
  assign g_vld = rr_on ? arb_vld : (int'(bus.sel) < N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer && rr_on) begin
      rr_ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;

  // An out-of-range select (N not a power of 2) simply grants nobody.
  assign g     = bus.sel;
  assign g_vld = (int'(bus.sel) < N);
`endif

  // Ready is one-hot on the granted channel and forced low while in reset.
  always_comb begin
    ready = '0;
    din   = '0;
    for (int i = 0; i < N; i++) begin
      if (!rst && load && g_vld && int'(g) == i) begin
        ready[i] = 1'b1;
        din      = bus.d[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer        = |(ready & bus.d_valid);
  assign bus.d_ready = ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
    end else if (load) begin
      y_valid_q <= xfer;
      if (xfer) begin
        y_q    <= din;
        y_ch_q <= g;
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.y_ch    = y_ch_q;
  assign bus.y_valid = y_valid_q;

endmodule
